mem_access_ctrl: RTL and testbench

Memory-stage access controller for the 16-bit pipelined processor. It sits directly downstream of the memory-stage decode logic and consumes its `e_mem`, `wr_mem` and `halt` strobes together with the ALU-computed address and store data. It runs the request/stall/done handshake with the multi-cycle data memory, holds the pipeline while an access is outstanding, and returns load data. It also raises the dump request on HALT and flags hung or illegal accesses.

---
 rtl/mem_access_ctrl_pkg.sv | 17 +
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_access_ctrl_timeout_cnt.sv | 36 +++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: state encodings
// and datapath/counter widths.
package mem_ctrl_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side strobes plus the request/stall/done bus to data memory.
// master = the access controller, slave = the surrounding pipeline and memory.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              e_mem;
  logic              wr_mem;
  logic              halt;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wr_data;
  logic              mem_stall;
  logic              mem_done;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              stall_out;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              createdump;
  logic              err;

  modport master (
    input  e_mem, wr_mem, halt, addr, wr_data, mem_stall, mem_done, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, stall_out, rd_data, rd_valid,
           createdump, err
  );

  modport slave (
    output e_mem, wr_mem, halt, addr, wr_data, mem_stall, mem_done, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, stall_out, rd_data, rd_valid,
           createdump, err
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Clearable saturating outstanding-cycle counter; expire_o flags the cycle in
// which the count would reach TIMEOUT_CYCLES.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // A clear means the access just made progress, so it never expires that cycle.
  assign expire_o = en_i && !clr_i && (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues requests, stalls the pipeline while an
// access is outstanding, returns load data. Optional macro MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.master bus
);

  state_e            state_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              wr_q;
  logic              rd_valid_q;
  logic              createdump_q;
  logic              err_q;

  logic misalign;
  logic idle_req;
  logic idle_issue;
  logic req_accept;
  logic cnt_en;
  logic cnt_clr;
  logic expire;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = bus.addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign idle_req   = (state_q == ST_IDLE) && bus.e_mem && !bus.halt;
  assign idle_issue = idle_req && !misalign;
  assign req_accept = (state_q == ST_REQ) && !bus.mem_stall;
  assign cnt_en     = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign cnt_clr    = idle_issue || req_accept;

  mem_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  // The first request cycle comes straight from the live inputs; later ones replay the registers.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = wr_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.stall_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.stall_out = bus.e_mem | bus.halt;
        if (idle_issue) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = bus.wr_mem;
          bus.mem_addr  = bus.addr;
          bus.mem_wdata = bus.wr_data;
        end else begin
          bus.mem_en = 1'b0;
        end
      end
      ST_REQ: begin
        bus.mem_en    = 1'b1;
        bus.stall_out = 1'b1;
      end
      ST_WAIT, ST_HALTED, ST_ERR: bus.stall_out = 1'b1;
      ST_DONE:                    bus.stall_out = 1'b0;
      default:                    bus.stall_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      createdump_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_valid_q   <= 1'b0;
      createdump_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.halt) begin
            state_q      <= ST_HALTED;
            createdump_q <= 1'b1;
          end else if (bus.e_mem && misalign) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else if (bus.e_mem) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wr_data;
            wr_q    <= bus.wr_mem;
            state_q <= bus.mem_stall ? ST_REQ : ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (!bus.mem_stall) begin
            state_q <= ST_WAIT;
          end else if (expire) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_REQ;
          end
        end
        // A completion arriving on the expiry cycle still counts as success.
        ST_WAIT: begin
          if (bus.mem_done) begin
            if (!wr_q) begin
              rd_data_q <= bus.mem_rdata;
            end else begin
              rd_data_q <= rd_data_q;
            end
            rd_valid_q <= !wr_q;
            state_q    <= ST_DONE;
          end else if (expire) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE:   state_q <= ST_IDLE;
        ST_HALTED: state_q <= ST_HALTED;
        ST_ERR:    state_q <= ST_ERR;
        default: begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.createdump = createdump_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and randomized accesses
// compared cycle by cycle against expectations derived from stall/latency arithmetic.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] model_rd;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic wr,
                         input logic [15:0] a, input logic [15:0] d, input logic st,
                         input logic rv, input logic [15:0] rd, input logic dump,
                         input logic er);
    chk1 ({tag, ".mem_en"},     bus.mem_en,     en);
    chk1 ({tag, ".mem_wr"},     bus.mem_wr,     wr);
    chk16({tag, ".mem_addr"},   bus.mem_addr,   a);
    chk16({tag, ".mem_wdata"},  bus.mem_wdata,  d);
    chk1 ({tag, ".stall_out"},  bus.stall_out,  st);
    chk1 ({tag, ".rd_valid"},   bus.rd_valid,   rv);
    chk16({tag, ".rd_data"},    bus.rd_data,    rd);
    chk1 ({tag, ".createdump"}, bus.createdump, dump);
    chk1 ({tag, ".err"},        bus.err,        er);
  endtask

  task automatic idle_inputs();
    bus.e_mem     = 1'b0;
    bus.wr_mem    = 1'b0;
    bus.halt      = 1'b0;
    bus.addr      = 16'h0000;
    bus.wr_data   = 16'h0000;
    bus.mem_stall = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  // Ends at posedge+1 with the design in its reset state.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rd = 16'h0000;
    @(negedge clk);
    chk_all(tag, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  // One access: s stall cycles at issue, mem_done k cycles after acceptance.
  // Expected: mem_en on cycles 0..s, stall_out on 0..s+k, DONE on s+k+1.
  task automatic run_access(input int s, input int k, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] rd, input bit gap);
    logic [15:0] exp_rd;
    for (int t = 0; t <= s + k + 1; t++) begin
      bus.e_mem     = 1'b1;
      bus.halt      = 1'b0;
      bus.wr_mem    = (t == 0) ? wr : 1'($urandom_range(0, 1));
      bus.addr      = (t == 0) ? a  : 16'($urandom);
      bus.wr_data   = (t == 0) ? d  : 16'($urandom);
      bus.mem_stall = (t < s) ? 1'b1 : ((t == s) ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.mem_done  = (t == s + k) ? 1'b1 :
                      ((t == s + k + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.mem_rdata = (t == s + k) ? rd : 16'($urandom);
      exp_rd = ((t == s + k + 1) && !wr) ? rd : model_rd;
      @(negedge clk);
      chk_all("access", (t <= s), wr, a, d, (t <= s + k),
              ((t == s + k + 1) && !wr), exp_rd, 1'b0, 1'b0);
      model_rd = exp_rd;
      @(posedge clk); #1;
    end
    if (gap) begin
      bus.e_mem     = 1'b0;
      bus.addr      = 16'($urandom);
      bus.mem_stall = 1'($urandom_range(0, 1));
      bus.mem_done  = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      @(negedge clk);
      chk_all("idle_gap", 1'b0, wr, a, d, 1'b0, 1'b0, model_rd, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_rd = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    run_access(0, 2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
    run_access(3, 2, 1'b1, 16'h0020, 16'h1234, 16'hFFFF, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_access(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFFE,
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Odd address
    do_reset("reset_pre_align");
`ifdef MEM_ALIGN_CHECK_EN
    for (int t = 0; t < 4; t++) begin
      bus.e_mem   = 1'b1;
      bus.wr_mem  = 1'b0;
      bus.addr    = 16'h0011;
      bus.wr_data = 16'h5555;
      @(negedge clk);
      chk_all("misalign", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, (t > 0));
      @(posedge clk); #1;
    end
`else
    run_access(0, 2, 1'b0, 16'h0011, 16'h5555, 16'hA5A5, 1'b1);
`endif

    // Timeout with no completion
    do_reset("reset_pre_timeout");
    bus.e_mem   = 1'b1;
    bus.wr_mem  = 1'b0;
    bus.addr    = 16'h0040;
    bus.wr_data = 16'h7777;
    @(negedge clk);
    chk_all("timeout_issue", 1'b1, 1'b0, 16'h0040, 16'h7777, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int t = 1; t <= 8; t++) begin
      bus.addr      = 16'($urandom);
      bus.mem_done  = (t == 6) ? 1'b1 : 1'b0;
      bus.mem_rdata = 16'hC0DE;
      @(negedge clk);
      chk_all("timeout", 1'b0, 1'b0, 16'h0040, 16'h7777, 1'b1, 1'b0, 16'h0000, 1'b0, (t >= 5));
      @(posedge clk); #1;
    end

    // Reset while waiting, then a stale completion
    do_reset("reset_pre_midwait");
    bus.e_mem   = 1'b1;
    bus.wr_mem  = 1'b0;
    bus.addr    = 16'h0080;
    bus.wr_data = 16'h0000;
    @(negedge clk);
    chk1("midwait_issue.mem_en", bus.mem_en, 1'b1);
    @(posedge clk); #1;
    for (int t = 1; t <= 2; t++) begin
      if (t == 2) begin
        rst = 1'b1;
        bus.e_mem = 1'b0;
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
      chk1("midwait.stall_out", bus.stall_out, 1'b1);
      chk1("midwait.mem_en", bus.mem_en, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_rd = 16'h0000;
    for (int t = 0; t < 3; t++) begin
      bus.mem_done  = (t == 0) ? 1'b1 : 1'b0;
      bus.mem_rdata = 16'hDEAD;
      @(negedge clk);
      chk_all("late_done", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    run_access(1, 1, 1'b0, 16'h00A0, 16'h0000, 16'h4242, 1'b1);

    // Halt has priority over a simultaneous access
    do_reset("reset_pre_halt");
    bus.halt  = 1'b1;
    bus.e_mem = 1'b1;
    bus.addr  = 16'h0100;
    @(negedge clk);
    chk_all("halt_idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int t = 1; t <= 22; t++) begin
      bus.halt     = 1'($urandom_range(0, 1));
      bus.mem_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all("halted", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, (t == 1), 1'b0);
      @(posedge clk); #1;
    end
    do_reset("reset_after_halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
